// File: rtl/mmio_input_port.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mmio_input_port                                            |
// | Description : Memory-mapped input responder for the Hack-style bus.      |
// |               Synchronises and debounces the DE0 buttons and switches,   |
// |               keeps sticky press/release flags and a btn[0] press count, |
// |               and serves them as three word registers.                   |
// | Ports       : clk       system clock (rising edge)                       |
// |               reset_n   asynchronous active-low reset                    |
// |               btn[2:0]  raw push buttons, 0 = pressed                    |
// |               sw[9:0]   raw slide switches, 1 = on                       |
// |               addressM  CPU data address                                 |
// |               writeM    CPU write strobe                                 |
// |               outM      CPU write data                                   |
// |               inM       read data, 0 outside this block's range          |
// |               hit       address falls in BASE_ADDR..BASE_ADDR+2          |
// |               irq       OR of all event flags                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mmio_input_port #(
  parameter logic [15:0] BASE_ADDR       = 16'h6000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  btn,
  input  logic [9:0]  sw,
  input  logic [15:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  output logic        hit,
  output logic        irq
);

  localparam int unsigned       c_PW         = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_PW-1:0]   c_TICK_MAX   = c_PW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]       c_OFF_DATA   = 16'd0;
  localparam logic [15:0]       c_OFF_EVENT  = 16'd1;
  localparam logic [15:0]       c_OFF_COUNT  = 16'd2;

  // Input vector layout: [9:0] switches, [12:10] buttons.
  logic [12:0]     r_sync1;
  logic [12:0]     r_sync2;
  logic [12:0]     r_sample;
  logic [12:0]     r_state;
  logic [c_PW-1:0] r_presc;
  logic [5:0]      r_event;
  logic [15:0]     r_count;

  logic [12:0]     w_synced;
  logic [12:0]     w_stable;
  logic [12:0]     w_state_next;
  logic            w_tick;
  logic [2:0]      w_press;
  logic [2:0]      w_release;
  logic [15:0]     w_offset;
  logic            w_hit;
  logic            w_wr_event;
  logic            w_wr_count;
  logic [5:0]      w_clr;
  logic [15:0]     w_count_base;
  logic [15:0]     w_rdata;

  // Two-flop synchronisers for all 13 asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 13'd0;
      r_sync2 <= 13'd0;
    end else begin
      r_sync1 <= {btn, sw};
      r_sync2 <= r_sync1;
    end
  end

  // Buttons are active-low on the board; flip them so 1 = pressed.
  assign w_synced = {~r_sync2[12:10], r_sync2[9:0]};

  // Debounce sample tick prescaler.
  assign w_tick = (r_presc == c_TICK_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_PW'(1);
    end
  end

  // A bit is accepted only when the synced value matches the sample taken
  // one tick earlier, i.e. it has held for a full tick interval.
  assign w_stable = ~(w_synced ^ r_sample);

  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      w_state_next = (w_stable & w_synced) | (~w_stable & r_state);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= 13'd0;
      r_state  <= 13'd0;
    end else begin
      if (w_tick) begin
        r_sample <= w_synced;
      end
      r_state <= w_state_next;
    end
  end

  // Edge detection on the debounced button state; flags set on the same
  // edge the state flips.
  assign w_press   =  w_state_next[12:10] & ~r_state[12:10];
  assign w_release = ~w_state_next[12:10] &  r_state[12:10];

  // Address decode. The subtraction wraps addresses below BASE_ADDR to large
  // values, so one unsigned compare covers both ends of the window.
  assign w_offset   = addressM - BASE_ADDR;
  assign w_hit      = (w_offset <= c_OFF_COUNT);
  assign w_wr_event = writeM && (w_offset == c_OFF_EVENT);
  assign w_wr_count = writeM && (w_offset == c_OFF_COUNT);

  // W1C mask; new events are OR-ed in after the clear so a set wins.
  assign w_clr = w_wr_event ? outM[5:0] : 6'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event <= 6'd0;
    end else begin
      r_event <= (r_event & ~w_clr) | {w_release, w_press};
    end
  end

  // A load and a press in the same cycle yield outM + 1.
  assign w_count_base = w_wr_count ? outM : r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 16'd0;
    end else begin
      r_count <= w_count_base + {15'd0, w_press[0]};
    end
  end

  // Same-cycle read path required by the Hack CPU.
  always_comb begin
    w_rdata = 16'd0;
    if (w_hit) begin
      case (w_offset)
        c_OFF_DATA:  w_rdata = {3'd0, r_state};
        c_OFF_EVENT: w_rdata = {10'd0, r_event};
        c_OFF_COUNT: w_rdata = r_count;
        default:     w_rdata = 16'd0;
      endcase
    end
  end

  assign inM = w_rdata;
  assign hit = w_hit;
  assign irq = |r_event;

endmodule
`default_nettype wire

// File: tb/tb_mmio_input_port.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mmio_input_port                                         |
// | Description : Directed self-checking bench for mmio_input_port with      |
// |               DEBOUNCE_CYCLES = 4 and hand-computed expected values.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mmio_input_port;

  localparam logic [15:0] c_BASE = 16'h6000;
  localparam logic [15:0] c_DATA = 16'h6000;
  localparam logic [15:0] c_EVT  = 16'h6001;
  localparam logic [15:0] c_CNT  = 16'h6002;

  logic        clk;
  logic        reset_n;
  logic [2:0]  btn;
  logic [9:0]  sw;
  logic [15:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        hit;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  mmio_input_port #(
    .BASE_ADDR       (c_BASE),
    .DEBOUNCE_CYCLES (4)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn      (btn),
    .sw       (sw),
    .addressM (addressM),
    .writeM   (writeM),
    .outM     (outM),
    .inM      (inM),
    .hit      (hit),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Clock edges since reset release; debounce ticks land where cyc % 4 == 0.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    addressM = a;
    #1;
    d = inM;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    step();
    writeM   = 1'b0;
  endtask

  // Step until the next edge is the one after a tick edge.
  task automatic align_tick();
    for (int i = 0; i < 4; i++) begin
      if ((cyc % 4) != 0) step();
    end
  endtask

  logic [15:0] d;

  initial begin
    reset_n  = 1'b0;
    btn      = 3'b111;
    sw       = 10'h3FF;
    addressM = c_DATA;
    writeM   = 1'b0;
    outM     = 16'h0000;

    // 1. Reset state, then switches debounce in.
    wait_cyc(3);
    rd(c_DATA, d); check_val("rst_data", d, 16'h0000);
    check_val("rst_hit", {15'd0, hit}, 16'h0001);
    check_val("rst_irq", {15'd0, irq}, 16'h0000);
    reset_n = 1'b1;
    wait_cyc(16);
    rd(c_DATA, d); check_val("sw_data", d, 16'h03FF);
    rd(c_EVT, d);  check_val("sw_event", d, 16'h0000);
    rd(c_CNT, d);  check_val("sw_count", d, 16'h0000);
    check_val("sw_irq", {15'd0, irq}, 16'h0000);

    // 2. Short glitch on btn[1] is filtered.
    btn = 3'b101;
    wait_cyc(2);
    btn = 3'b111;
    wait_cyc(16);
    rd(c_DATA, d); check_val("glitch_data", d, 16'h03FF);
    rd(c_EVT, d);  check_val("glitch_event", d, 16'h0000);

    // 3. Press and release btn[0].
    btn = 3'b110;
    wait_cyc(16);
    rd(c_DATA, d); check_val("press_data", d, 16'h07FF);
    rd(c_EVT, d);  check_val("press_event", d, 16'h0001);
    rd(c_CNT, d);  check_val("press_count", d, 16'h0001);
    check_val("press_irq", {15'd0, irq}, 16'h0001);
    btn = 3'b111;
    wait_cyc(16);
    rd(c_DATA, d); check_val("rel_data", d, 16'h03FF);
    rd(c_EVT, d);  check_val("rel_event", d, 16'h0009);

    // 4. W1C, then clear coinciding with a new press (bit0 set must win).
    wr(c_EVT, 16'h0001);
    rd(c_EVT, d);  check_val("w1c_event", d, 16'h0008);
    align_tick();
    btn = 3'b110;
    wait_cyc(7);
    wr(c_EVT, 16'h0009);
    rd(c_EVT, d);  check_val("setwins_event", d, 16'h0001);
    rd(c_CNT, d);  check_val("setwins_count", d, 16'h0002);
    btn = 3'b111;
    wait_cyc(16);
    rd(c_EVT, d);  check_val("rel2_event", d, 16'h0009);

    // 5. COUNT load, wrap, and load coinciding with a press.
    wr(c_CNT, 16'hFFFF);
    rd(c_CNT, d);  check_val("load_count", d, 16'hFFFF);
    btn = 3'b110;
    wait_cyc(16);
    rd(c_CNT, d);  check_val("wrap_count", d, 16'h0000);
    btn = 3'b111;
    wait_cyc(16);
    align_tick();
    btn = 3'b110;
    wait_cyc(7);
    wr(c_CNT, 16'h0010);
    rd(c_CNT, d);  check_val("loadpress_count", d, 16'h0011);

    // 6. Out-of-range accesses, writeM=0, and reset mid-debounce.
    rd(16'h6003, d); check_val("oor3_inm", d, 16'h0000);
    check_val("oor3_hit", {15'd0, hit}, 16'h0000);
    rd(16'h0000, d); check_val("oor0_inm", d, 16'h0000);
    check_val("oor0_hit", {15'd0, hit}, 16'h0000);
    rd(16'h5FFF, d); check_val("below_hit", {15'd0, hit}, 16'h0000);
    wr(16'h6003, 16'hFFFF);
    wr(16'h0000, 16'hFFFF);
    wr(c_DATA, 16'hFFFF);
    addressM = c_CNT; outM = 16'h1234; writeM = 1'b0;
    step();
    rd(c_DATA, d); check_val("oor_data", d, 16'h07FF);
    rd(c_EVT, d);  check_val("oor_event", d, 16'h0009);
    rd(c_CNT, d);  check_val("oor_count", d, 16'h0011);

    btn = 3'b111;
    wait_cyc(5);
    #3;
    reset_n = 1'b0;
    #1;
    rd(c_DATA, d); check_val("midrst_data", d, 16'h0000);
    rd(c_EVT, d);  check_val("midrst_event", d, 16'h0000);
    rd(c_CNT, d);  check_val("midrst_count", d, 16'h0000);
    check_val("midrst_irq", {15'd0, irq}, 16'h0000);
    btn = 3'b110;
    step();
    reset_n = 1'b1;
    wait_cyc(16);
    rd(c_DATA, d); check_val("held_data", d, 16'h07FF);
    rd(c_EVT, d);  check_val("held_event", d, 16'h0001);
    rd(c_CNT, d);  check_val("held_count", d, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
